water_pump_controller: RTL and testbench

Sequential fill controller for the tank level sensor array. It qualifies and debounces the 8-bit active-low one-cold sensor vector into a 3-bit level, then runs a hysteresis state machine that drives the pump. The FSM enforces a minimum off-time between pump runs and raises a latched fault on a bad sensor pattern or an over-long run. It sits between the raw sensor pins and the pump driver output.

---
 rtl/water_ctrl_pkg.sv | 42 ++++
 rtl/water_level_debouncer.sv | 69 ++++++
 rtl/water_pump_controller.sv | 137 +++++++++++++
 tb/tb_water_pump_controller.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/water_ctrl_pkg.sv
// ============================================================================
// Module   : water_ctrl_pkg
// Brief    : Shared types, constants and the one-cold sensor decoder for the
//            water pump controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package water_ctrl_pkg;

    localparam int SENSOR_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FILLING  = 2'd1,
        COOLDOWN = 2'd2,
        FAULT    = 2'd3
    } pump_state_e;

    // Returns {valid, level}; invalid patterns report level 0.
    function automatic logic [3:0] onecold_decode(input logic [SENSOR_W-1:0] raw_n);
        logic [3:0] result;
        int         zeros;
        result = 4'b0000;
        zeros  = 0;
        for (int i = 0; i < SENSOR_W; i++) begin
            if (!raw_n[i]) begin
                zeros       = zeros + 1;
                result[2:0] = 3'(i);
            end
        end
        if (zeros == 1) begin
            result[3] = 1'b1;
        end else begin
            result[2:0] = 3'd0;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/water_level_debouncer.sv
// ============================================================================
// Module   : water_level_debouncer
// Brief    : Synchronizes and decodes the active-low sensor vector, then
//            accepts a level only after DEBOUNCE_CYCLES identical samples.
// Revision : 1.0
// ============================================================================
`default_nettype none

module water_level_debouncer
    import water_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SENSOR_W-1:0] sensor_n,
    output logic [2:0]          level,
    output logic                level_valid
);

    localparam int             CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [SENSOR_W-1:0] sync1;
    logic [SENSOR_W-1:0] sync2;
    logic [3:0]          sample;
    logic [3:0]          cand;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;

    assign sample = onecold_decode(sync2);

    always_comb begin
        cnt_next = cnt;
        if (sample != cand) begin
            cnt_next = CNT_W'(1);
        end else if (cnt < DEB_MAX) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    // Synchronizer idles at all-ones so no sensor appears active out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '1;
            sync2       <= '1;
            cand        <= 4'b0000;
            cnt         <= '0;
            level       <= 3'd0;
            level_valid <= 1'b0;
        end else begin
            sync1 <= sensor_n;
            sync2 <= sync1;
            cand  <= sample;
            cnt   <= cnt_next;
            if (cnt_next == DEB_MAX) begin
                if (sample[3]) begin
                    level       <= sample[2:0];
                    level_valid <= 1'b1;
                end else begin
                    level_valid <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/water_pump_controller.sv
// ============================================================================
// Module   : water_pump_controller
// Brief    : Hysteresis fill controller with minimum off-time and latched
//            fault. Define WATER_PUMP_TIMEOUT_EN to bound each pump run.
// Revision : 1.0
// ============================================================================
`default_nettype none

module water_pump_controller
    import water_ctrl_pkg::*;
#(
    parameter int LOW_THRESH      = 2,
    parameter int HIGH_THRESH     = 6,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MIN_OFF_CYCLES  = 64,
    parameter int MAX_RUN_CYCLES  = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SENSOR_W-1:0] sensor_n,
    input  logic                enable,
    input  logic                fault_clr,
    output logic                pump_on,
    output logic [2:0]          level,
    output logic                level_valid,
    output logic                fault,
    output logic [1:0]          state
);

    localparam int               OFF_W    = $clog2(MIN_OFF_CYCLES + 1);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(MIN_OFF_CYCLES - 1);
    localparam logic [2:0]       LOW_L    = 3'(LOW_THRESH);
    localparam logic [2:0]       HIGH_L   = 3'(HIGH_THRESH);

    generate
        if (!(LOW_THRESH < HIGH_THRESH && HIGH_THRESH <= 7 && DEBOUNCE_CYCLES >= 1 &&
              MIN_OFF_CYCLES >= 1 && MAX_RUN_CYCLES >= 1)) begin : g_bad_params
            $error("water_pump_controller: illegal parameter combination");
        end
    endgenerate

    pump_state_e      st;
    logic [OFF_W-1:0] off_cnt;
    logic             timeout_hit;

    water_level_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk         (clk),
        .rst_n       (rst_n),
        .sensor_n    (sensor_n),
        .level       (level),
        .level_valid (level_valid)
    );

`ifdef WATER_PUMP_TIMEOUT_EN
    localparam int               RUN_W    = $clog2(MAX_RUN_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_RUN_CYCLES - 1);

    logic [RUN_W-1:0] run_cnt;

    assign timeout_hit = (run_cnt == RUN_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if (st != FILLING) begin
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + RUN_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            pump_on <= 1'b0;
            fault   <= 1'b0;
            off_cnt <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (enable && level_valid && level <= LOW_L) begin
                        st      <= FILLING;
                        pump_on <= 1'b1;
                    end
                end
                FILLING: begin
                    if (!level_valid) begin
                        st      <= FAULT;
                        pump_on <= 1'b0;
                        fault   <= 1'b1;
                    end else if (level >= HIGH_L) begin
                        st      <= COOLDOWN;
                        pump_on <= 1'b0;
                        off_cnt <= '0;
                    end else if (timeout_hit) begin
                        st      <= FAULT;
                        pump_on <= 1'b0;
                        fault   <= 1'b1;
                    end else if (!enable) begin
                        st      <= COOLDOWN;
                        pump_on <= 1'b0;
                        off_cnt <= '0;
                    end
                end
                COOLDOWN: begin
                    if (off_cnt == OFF_LAST) begin
                        st <= IDLE;
                    end else begin
                        off_cnt <= off_cnt + OFF_W'(1);
                    end
                end
                FAULT: begin
                    if (fault_clr) begin
                        st      <= COOLDOWN;
                        fault   <= 1'b0;
                        off_cnt <= '0;
                    end
                end
                default: begin
                    st      <= IDLE;
                    pump_on <= 1'b0;
                    fault   <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_water_pump_controller.sv
// ============================================================================
// Module   : tb_water_pump_controller
// Brief    : Directed and randomized self-checking bench for the water pump
//            controller against a behavioural reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_water_pump_controller;

    localparam int LOW  = 2;
    localparam int HIGH = 6;
    localparam int DEB  = 16;
    localparam int OFF  = 64;
    localparam int MAXR = 32;

`ifdef WATER_PUMP_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sensor_n;
    logic       enable;
    logic       fault_clr;
    logic       pump_on;
    logic [2:0] level;
    logic       level_valid;
    logic       fault;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    water_pump_controller #(
        .LOW_THRESH      (LOW),
        .HIGH_THRESH     (HIGH),
        .DEBOUNCE_CYCLES (DEB),
        .MIN_OFF_CYCLES  (OFF),
        .MAX_RUN_CYCLES  (MAXR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sensor_n    (sensor_n),
        .enable      (enable),
        .fault_clr   (fault_clr),
        .pump_on     (pump_on),
        .level       (level),
        .level_valid (level_valid),
        .fault       (fault),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Reference model: pipeline delay, run length of identical samples,
    // and time spent in the current mode.
    logic [7:0] m_s1, m_s2;
    bit         m_cv;
    int         m_cl, m_run, m_level, m_state, m_t;
    bit         m_valid;

    task automatic model_reset();
        m_s1 = 8'hFF; m_s2 = 8'hFF;
        m_cv = 1'b0; m_cl = 0; m_run = 0;
        m_level = 0; m_valid = 1'b0;
        m_state = 0; m_t = 0;
    endtask

    task automatic decode(input logic [7:0] s, output bit v, output int l);
        logic [7:0] inv;
        inv = ~s;
        v   = ($countones(inv) == 1);
        l   = v ? $clog2(inv) : 0;
    endtask

    task automatic model_step();
        bit sv;
        int sl;
        bit ov;
        int ol;
        ov = m_valid;
        ol = m_level;
        decode(m_s2, sv, sl);
        m_s2 = m_s1;
        m_s1 = sensor_n;
        if (sv != m_cv || sl != m_cl) begin
            m_cv = sv; m_cl = sl; m_run = 1;
        end else if (m_run < DEB) begin
            m_run++;
        end
        if (m_run == DEB) begin
            if (m_cv) begin
                m_level = m_cl; m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        case (m_state)
            0: if (enable && ov && ol <= LOW) begin m_state = 1; m_t = 0; end
            1: begin
                if (!ov) m_state = 3;
                else if (ol >= HIGH) begin m_state = 2; m_t = 0; end
                else if (TIMEOUT_EN && m_t == MAXR - 1) m_state = 3;
                else if (!enable) begin m_state = 2; m_t = 0; end
                else m_t++;
            end
            2: if (m_t == OFF - 1) m_state = 0; else m_t++;
            default: if (fault_clr) begin m_state = 2; m_t = 0; end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("pump_on",     32'(pump_on),     32'(m_state == 1));
        check("level",       32'(level),       32'(m_level));
        check("level_valid", 32'(level_valid), 32'(m_valid));
        check("fault",       32'(fault),       32'(m_state == 3));
        check("state",       32'(state),       32'(m_state));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int n;
        int run_len;
        int hold;

        rst_n = 1'b0; sensor_n = 8'b1111_1110; enable = 1'b0; fault_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pump_on", 32'(pump_on), 0);
        check("rst_level", 32'(level), 0);
        check("rst_level_valid", 32'(level_valid), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_state", 32'(state), 0);
        rst_n = 1'b1;

        // Level 0 accepted exactly 2+DEB cycles after release.
        ticks(DEB + 1);
        check("lv_before_latency", 32'(level_valid), 0);
        tick();
        check("lv_at_latency", 32'(level_valid), 1);
        enable = 1'b1;
        tick();
        check("pump_start", 32'(pump_on), 1);

        // Rise to level 6: stop, then exactly OFF cycles of cooldown.
        sensor_n = 8'b1011_1111;
        ticks(DEB + 1);
        check("lvl6_early", 32'(level), 0);
        tick();
        check("lvl6_reached", 32'(level), 6);
        check("pump_still_on", 32'(pump_on), 1);
        tick();
        check("pump_stop", 32'(pump_on), 0);
        check("cooldown_entry", 32'(state), 2);
        n = 1;
        for (int i = 0; i < 2 * OFF && state == 2; i++) begin
            tick();
            if (state == 2) n++;
        end
        check("cooldown_len", 32'(n), 32'(OFF));
        check("idle_after_cool", 32'(state), 0);

        // Level 1 fill, then a 10-cycle glitch to level 3.
        sensor_n = 8'b1111_1101;
        ticks(DEB + 2);
        check("lvl1", 32'(level), 1);
        tick();
        check("refill", 32'(pump_on), 1);
        run_len = 1;
        sensor_n = 8'b1111_0111;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("glitch_level", 32'(level), 1);
            if (pump_on) run_len++;
        end
        sensor_n = 8'b1111_1101;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("post_glitch_level", 32'(level), 1);
            if (pump_on) run_len++;
        end
        check("glitch_pump", 32'(pump_on), 1);

`ifdef WATER_PUMP_TIMEOUT_EN
        for (int i = 0; i < 100; i++) begin
            tick();
            if (pump_on) run_len++;
            else break;
        end
        check("run_len", 32'(run_len), 32'(MAXR));
        check("timeout_fault", 32'(fault), 1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("timeout_clr_state", 32'(state), 2);
        check("timeout_clr_fault", 32'(fault), 0);
`else
        ticks(60);
        check("unbounded_run", 32'(pump_on), 1);
        enable = 1'b0;
        tick();
        check("disable_cool", 32'(state), 2);
        enable = 1'b1;
`endif
        for (int i = 0; i < 2 * OFF && state != 0; i++) tick();
        tick();
        check("fill_again", 32'(state), 1);

        // All-ones sensor while filling: fault, then clear into cooldown.
        sensor_n = 8'hFF;
        ticks(DEB + 1);
        check("lv_hold", 32'(level_valid), 1);
        tick();
        check("lv_drop", 32'(level_valid), 0);
        tick();
        check("bad_fault", 32'(fault), 1);
        check("bad_pump", 32'(pump_on), 0);
        ticks(3);
        check("fault_latched", 32'(state), 3);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("clr_state", 32'(state), 2);
        check("clr_fault", 32'(fault), 0);

        // Asynchronous reset in the middle of a fill.
        sensor_n = 8'b1111_1101;
        for (int i = 0; i < 200 && state != 1; i++) tick();
        check("fill_before_rst", 32'(state), 1);
        ticks(3);
        #2 rst_n = 1'b0;
        #1;
        check("async_pump", 32'(pump_on), 0);
        check("async_state", 32'(state), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic.
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 9))
                    0:       sensor_n = 8'hFF;
                    1:       sensor_n = 8'($urandom);
                    default: sensor_n = ~(8'd1 << $urandom_range(0, 7));
                endcase
                hold = $urandom_range(1, 40);
            end
            hold--;
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            fault_clr = ($urandom_range(0, 29) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
